// File: rtl/game_pkg.sv
// Shared game constants: screen bounds, default sprite sizes, life and
// invulnerability defaults, and the 2-bit encoding of the hit-judge FSM.
package game_pkg;

    // Visible screen bounds in pixels
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Default sprite box sizes
    localparam int BULLET_W_DEF = 8;
    localparam int BULLET_H_DEF = 8;
    localparam int PLAYER_W_DEF = 32;
    localparam int PLAYER_H_DEF = 32;

    // Default life count and invulnerability length (frames)
    localparam int LIVES_DEF      = 3;
    localparam int INV_FRAMES_DEF = 60;

    // Hit-judge FSM encoding
    localparam logic [1:0] ST_PLAY   = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_OVER   = 2'd2;

endpackage

// File: rtl/box_overlap.sv
// Purely combinational axis-aligned box overlap test between one bullet
// box and the player box. Edges that only touch do not count as overlap.
// Ports:
//   bx, by   bullet top-left corner (11-bit x, 10-bit y)
//   px, py   player top-left corner (11-bit x, 10-bit y)
//   overlap  1 when the two boxes share at least one pixel
module box_overlap
    import game_pkg::*;
#(
    parameter int BULLET_W = BULLET_W_DEF,
    parameter int BULLET_H = BULLET_H_DEF,
    parameter int PLAYER_W = PLAYER_W_DEF,
    parameter int PLAYER_H = PLAYER_H_DEF
) (
    input  logic [10:0] bx,
    input  logic [9:0]  by,
    input  logic [10:0] px,
    input  logic [9:0]  py,
    output logic        overlap
);

    localparam logic [11:0] BW = 12'(BULLET_W);
    localparam logic [11:0] BH = 12'(BULLET_H);
    localparam logic [11:0] PW = 12'(PLAYER_W);
    localparam logic [11:0] PH = 12'(PLAYER_H);

    // 12-bit operands leave headroom so corner+size never wraps
    logic [11:0] bx_s;
    logic [11:0] by_s;
    logic [11:0] px_s;
    logic [11:0] py_s;

    assign bx_s = {1'b0, bx};
    assign by_s = {2'b00, by};
    assign px_s = {1'b0, px};
    assign py_s = {2'b00, py};

    // Strict separating-axis test on both axes
    always_comb begin
        overlap = (bx_s < (px_s + PW)) && (px_s < (bx_s + BW)) &&
                  (by_s < (py_s + PH)) && (py_s < (by_s + BH));
    end

endmodule

// File: rtl/bullet_hit_judge.sv
// Per-frame collision judge between a set of bullets and the player box.
// Tracks lives, runs an invulnerability window after each non-fatal hit and
// holds a sticky game-over state until reset.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   frame      one-cycle frame tick; positions are sampled on this cycle
//   bullet_x   packed bullet x coordinates, 11 bits per bullet
//   bullet_y   packed bullet y coordinates, 10 bits per bullet
//   player_x   player top-left x
//   player_y   player top-left y
//   hit        one-cycle pulse when a life is lost
//   lives      remaining lives
//   invuln     high during the invulnerability window
//   over       game over, sticky until rst
module bullet_hit_judge
    import game_pkg::*;
#(
    parameter int N_BULLETS  = 2,
    parameter int BULLET_W   = BULLET_W_DEF,
    parameter int BULLET_H   = BULLET_H_DEF,
    parameter int PLAYER_W   = PLAYER_W_DEF,
    parameter int PLAYER_H   = PLAYER_H_DEF,
    parameter int LIVES      = LIVES_DEF,
    parameter int INV_FRAMES = INV_FRAMES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic [11*N_BULLETS-1:0] bullet_x,
    input  logic [10*N_BULLETS-1:0] bullet_y,
    input  logic [9:0]              player_x,
    input  logic [9:0]              player_y,
    output logic                    hit,
    output logic [2:0]              lives,
    output logic                    invuln,
    output logic                    over
);

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] INV_INIT   = 8'(INV_FRAMES);

    logic [N_BULLETS-1:0] overlap_s;
    logic                 any_hit_s;
    logic [10:0]          px_ext_s;

    logic [1:0] state_r;
    logic [2:0] lives_r;
    logic [7:0] inv_cnt_r;
    logic       hit_r;
    logic       invuln_r;
    logic       over_r;

    logic [1:0] state_s;
    logic [2:0] lives_s;
    logic [7:0] inv_cnt_s;
    logic       hit_s;

    assign px_ext_s = {1'b0, player_x};

    for (genvar i = 0; i < N_BULLETS; i++) begin : g_bullet
        box_overlap #(
            .BULLET_W(BULLET_W),
            .BULLET_H(BULLET_H),
            .PLAYER_W(PLAYER_W),
            .PLAYER_H(PLAYER_H)
        ) u_overlap (
            .bx      (bullet_x[11*i +: 11]),
            .by      (bullet_y[10*i +: 10]),
            .px      (px_ext_s),
            .py      (player_y),
            .overlap (overlap_s[i])
        );
    end

    // Several simultaneous overlaps collapse into one hit
    assign any_hit_s = |overlap_s;

    // Next-state, life and invulnerability-counter logic
    always_comb begin
        state_s   = state_r;
        lives_s   = lives_r;
        inv_cnt_s = inv_cnt_r;
        hit_s     = 1'b0;
        if (frame) begin
            case (state_r)
                ST_PLAY: begin
                    if (any_hit_s) begin
                        hit_s = 1'b1;
                        if (lives_r > 3'd1) begin
                            lives_s   = lives_r - 3'd1;
                            inv_cnt_s = INV_INIT;
                            state_s   = ST_INVULN;
                        end else begin
                            lives_s = 3'd0;
                            state_s = ST_OVER;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_INVULN: begin
                    // Overlaps ignored; leave on the frame that consumes the last count
                    inv_cnt_s = inv_cnt_r - 8'd1;
                    if (inv_cnt_r == 8'd1) begin
                        state_s = ST_PLAY;
                    end else begin
                        state_s = ST_INVULN;
                    end
                end
                ST_OVER: begin
                    state_s = ST_OVER;
                end
                default: begin
                    // Unreachable encoding: recover into a safe state
                    state_s   = ST_PLAY;
                    inv_cnt_s = 8'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_PLAY;
            lives_r   <= LIVES_INIT;
            inv_cnt_r <= 8'd0;
            hit_r     <= 1'b0;
            invuln_r  <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            lives_r   <= lives_s;
            inv_cnt_r <= inv_cnt_s;
            hit_r     <= hit_s;
            invuln_r  <= (state_s == ST_INVULN);
            over_r    <= (state_s == ST_OVER);
        end
    end

    assign hit    = hit_r;
    assign lives  = lives_r;
    assign invuln = invuln_r;
    assign over   = over_r;

endmodule

// File: tb/tb_bullet_hit_judge.sv
// Scoreboard bench for bullet_hit_judge: the driver updates a plain
// reference model on every frame/reset and queues the expected outputs;
// a monitor pops and compares after each sampled frame or reset, and
// checks that hit stays low on all other cycles.
module tb_bullet_hit_judge;

    localparam int NB  = 2;
    localparam int BW  = 8;
    localparam int BH  = 8;
    localparam int PW  = 32;
    localparam int PH  = 32;
    localparam int LV  = 3;
    localparam int INV = 60;

    typedef struct {
        logic       hit;
        logic [2:0] lives;
        logic       invuln;
        logic       over;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame;
    logic [11*NB-1:0] bullet_x;
    logic [10*NB-1:0] bullet_y;
    logic [9:0]      player_x;
    logic [9:0]      player_y;
    logic            hit;
    logic [2:0]      lives;
    logic            invuln;
    logic            over;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_lives;
    int m_inv_left;
    bit m_over;

    always #5 clk = ~clk;

    bullet_hit_judge #(
        .N_BULLETS(NB), .BULLET_W(BW), .BULLET_H(BH),
        .PLAYER_W(PW), .PLAYER_H(PH), .LIVES(LV), .INV_FRAMES(INV)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame),
        .bullet_x(bullet_x), .bullet_y(bullet_y),
        .player_x(player_x), .player_y(player_y),
        .hit(hit), .lives(lives), .invuln(invuln), .over(over)
    );

    function automatic bit boxes_overlap(int bx, int by, int px, int py);
        return (bx < px + PW) && (px < bx + BW) && (by < py + PH) && (py < by + BH);
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.hit = 1'b0; e.lives = 3'(LV); e.invuln = 1'b0; e.over = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_lives = LV; m_inv_left = 0; m_over = 1'b0;
        exp_q.push_back(reset_exp());
    endtask

    // Apply one cycle of stimulus at the falling edge and queue expectations
    task automatic step(input bit f, input bit r, input int bx0, input int by0,
                        input int bx1, input int by1, input int px, input int py);
        exp_t e;
        bit   hit_now;
        @(negedge clk);
        frame = f; rst = r;
        bullet_x = {11'(bx1), 11'(bx0)};
        bullet_y = {10'(by1), 10'(by0)};
        player_x = 10'(px);
        player_y = 10'(py);
        if (r) begin
            model_reset();
        end else if (f) begin
            hit_now = 1'b0;
            if (m_over) begin
                hit_now = 1'b0;
            end else if (m_inv_left > 0) begin
                m_inv_left--;
            end else if (boxes_overlap(bx0, by0, px, py) || boxes_overlap(bx1, by1, px, py)) begin
                hit_now = 1'b1;
                m_lives--;
                if (m_lives == 0) m_over = 1'b1;
                else m_inv_left = INV;
            end
            e.hit = hit_now; e.lives = 3'(m_lives);
            e.invuln = (m_inv_left > 0); e.over = m_over;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one comparison per sampled event, hit-idle check otherwise
    initial begin
        bit   ev;
        exp_t e;
        forever begin
            @(posedge clk);
            ev = rst || frame;
            @(negedge clk);
            if (ev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty: DUT event with no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (hit !== e.hit || lives !== e.lives || invuln !== e.invuln || over !== e.over) begin
                        failures++;
                        $display("FAIL outputs @%0t: got hit=%b lives=%0d invuln=%b over=%b, expected hit=%b lives=%0d invuln=%b over=%b",
                                 $time, hit, lives, invuln, over, e.hit, e.lives, e.invuln, e.over);
                    end
                end
            end else begin
                checks++;
                if (hit !== 1'b0) begin
                    failures++;
                    $display("FAIL hit_idle @%0t: got hit=%b, expected 0", $time, hit);
                end
            end
        end
    end

    initial begin
        int px, py;
        rst = 1'b1; frame = 1'b0;
        bullet_x = '0; bullet_y = '0; player_x = 10'd400; player_y = 10'd300;
        model_reset();
        step(0, 1, 200, 500, 0, 0, 400, 300);
        // Idle frames with no overlap
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 200, 500, 0, 0, 400, 300);
            step(0, 0, 200, 500, 0, 0, 400, 300);
        end
        // Direct hit, then stay overlapping through the whole window
        step(1, 0, 400, 300, 0, 0, 400, 300);
        step(0, 0, 400, 300, 0, 0, 400, 300);
        for (int i = 0; i < INV + 1; i++) step(1, 0, 400, 300, 0, 0, 400, 300);
        // Reset, then both bullets overlap in one frame
        step(0, 1, 200, 500, 0, 0, 400, 300);
        step(1, 0, 410, 310, 420, 320, 400, 300);
        for (int i = 0; i < INV; i++) step(1, 0, 200, 500, 0, 0, 400, 300);
        // Edge touch on x and y: no hit
        step(1, 0, 392, 300, 400, 332, 400, 300);
        step(1, 0, 432, 300, 400, 292, 400, 300);
        // Hit to lives=1, wait out the window, fatal hit, stay over
        step(1, 0, 393, 300, 0, 0, 400, 300);
        for (int i = 0; i < INV; i++) step(1, 0, 0, 0, 0, 0, 400, 300);
        step(1, 0, 400, 300, 0, 0, 400, 300);
        for (int i = 0; i < 5; i++) step(1, 0, 400, 300, 400, 300, 400, 300);
        // Reset wins over a simultaneous frame
        step(1, 1, 400, 300, 0, 0, 400, 300);
        step(0, 0, 400, 300, 0, 0, 400, 300);
        // Randomized phase around the player box
        for (int i = 0; i < 6000; i++) begin
            px = (i % 500 < 250) ? 400 : $urandom_range(0, 600);
            py = (i % 500 < 250) ? 300 : $urandom_range(0, 440);
            step($urandom_range(0, 1), ($urandom_range(0, 399) == 0),
                 (px > 40 ? px - 40 : 0) + $urandom_range(0, 80), (py > 40 ? py - 40 : 0) + $urandom_range(0, 80),
                 $urandom_range(0, 2047), $urandom_range(0, 1023), px, py);
        end
        step(0, 0, 0, 0, 0, 0, 400, 300);
        step(0, 0, 0, 0, 0, 0, 400, 300);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bullet_hit_judge.md
# bullet_hit_judge

Collision and life-tracking stage directly downstream of the bullet movers: every frame it compares each bullet's position against the player's box. It decrements a life counter on a hit, runs an invulnerability window after each hit, and raises a sticky game-over flag when lives run out. Its outputs drive the display/score logic and the game-over screen.

## Interface
Parameters:
- N_BULLETS, 2, number of bullet position pairs checked
- BULLET_W, 8, bullet box width in pixels
- BULLET_H, 8, bullet box height in pixels
- PLAYER_W, 32, player box width in pixels
- PLAYER_H, 32, player box height in pixels
- LIVES, 3, lives at reset (1..7)
- INV_FRAMES, 60, invulnerability length in frames after a non-fatal hit (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous and active-high
- frame  in  1  one-cycle frame-tick pulse, the same strobe that moves the bullets
- bullet_x  in  11*N_BULLETS  bullet i x at bits [11i+10:11i] (top-left corner)
- bullet_y  in  10*N_BULLETS  bullet i y at bits [10i+9:10i]
- player_x  in  10  player top-left x
- player_y  in  10  player top-left y
- hit  out  1  one-cycle pulse when a life is lost
- lives  out  3  remaining lives
- invuln  out  1  high during the invulnerability window
- over  out  1  game over, sticky until rst

## Operation
- Overlap test per bullet, computed combinationally:
  - bx < px+PLAYER_W && px < bx+BULLET_W && by < py+PLAYER_H && py < by+BULLET_H.
  - Operands are zero-extended to 12 bits before the adds, so no wrap occurs.
  - player_x is zero-extended to 11 bits.
  - Strict `<`: boxes that only touch edges do not overlap.
- any_hit = OR of all bullet overlaps. Several bullets overlapping in one frame count as a single hit.
- FSM states: PLAY, INVULN, OVER.
  - PLAY:
    - On frame with any_hit and lives>1: lives−1, hit pulses, inv_cnt←INV_FRAMES, go to INVULN.
    - On frame with any_hit and lives==1: lives←0, hit pulses, go to OVER.
  - INVULN:
    - Overlaps are ignored.
    - On each frame, inv_cnt−1. On the frame where inv_cnt==1, go to PLAY.
    - A bullet still overlapping on the first PLAY frame counts as a new hit.
  - OVER: absorbing. Inputs are ignored, and only rst leaves this state.
- Output decodes: invuln = (state==INVULN); over = (state==OVER).
- Nothing changes on cycles where frame==0.

## Timing
- Reset values: state=PLAY, lives=LIVES, inv_cnt=0, hit=0, invuln=0, over=0.
- Positions are sampled in the cycle where frame==1. These are the pre-move values, because the movers update on that same edge.
- All outputs are registered and update on the clock edge that samples frame. hit is high for exactly the following cycle.
- rst has priority over frame in the same cycle. A rst asserted mid-INVULN or in OVER returns the block to the reset values on the next edge.
- frame held high for k cycles is treated as k ticks. Upstream must guarantee single-cycle pulses.

## Structure
- Shared package `game_pkg`:
  - screen bounds
  - default sprite sizes (BULLET_W/H, PLAYER_W/H)
  - LIVES and INV_FRAMES defaults
  - FSM state encoding (2-bit: PLAY=0, INVULN=1, OVER=2)
- Sub-module `box_overlap`:
  - purely combinational; parameters are the box sizes
  - inputs are two corners; output is one overlap bit
  - instantiated N_BULLETS times in a generate loop
- Top level holds the FSM, the life counter and the 8-bit inv_cnt.

## Test plan
- Reset with bullet (200,500) and player (400,300), issue 10 frames → lives=3, hit never pulses, over=0.
- Place bullet0 at (400,300) on the player, issue 1 frame → hit pulses one cycle, lives=2, invuln=1.
- Keep overlap through INV_FRAMES=60 frames:
  - lives stays 2 for frames 1–60
  - invuln drops after frame 60
  - frame 61 hits → lives=1
- Both bullets overlap in the same frame → lives decrements by 1 only.
- Edge touch, bullet0 at (392,300) where 392+8==400 → no hit.
- Fatal hit and reset:
  - with lives=1, a hit → lives=0, over=1, and over stays 1 through 5 more overlapping frames
  - rst together with frame → lives=3, over=0 next cycle
